id_stage: RTL
=============

# id_stage

Instruction decode pipeline stage; sits directly downstream of `if_stage` and upstream of the execute stage. Consumes the fetch pipeline register and the instruction memory response, and holds a returned instruction word across stall cycles. Decodes RV32I fields, immediates and control, drives register-file read addresses, and latches everything plus RVFI tracking into `id_stage_reg`. Inserts bubbles on flush or when no instruction is available.

## Interface
- No parameters; reset PC/NOP constants come from `rv32i_types`.
- `clk` in 1: single clock, all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `i_if_stage_reg` in `if_stage_t`: pc, pc_next and rvfi of the fetched instruction.
- `imem_rdata` in 32: instruction word; valid only in the cycle `imem_resp`=1.
- `imem_resp` in 1: instruction memory response strobe.
- `id_reg_we` in 1: stage advance enable from the hazard unit; 0 = stall and hold everything.
- `i_flush` in 1: squash the instruction in decode; a taken branch/jump resolved downstream.
- `rs1_addr` out 5: register-file read address, combinational from the current instruction.
- `rs2_addr` out 5: same, for rs2.
- `rs1_rdata` in 32, `rs2_rdata` in 32: register-file read data, same cycle.
- `id_stage_reg` out `id_stage_t`: decode pipeline register.

## Operation
- Instruction source: `insn = imem_resp ? imem_rdata : hold_insn` when `hold_valid`=1; otherwise `insn` = NOP (0x00000013), `insn_avail`=`imem_resp|hold_valid`.
- Hold register: `imem_resp`=1 and `id_reg_we`=0 → `hold_insn`<=`imem_rdata` and `hold_valid`<=1. `id_reg_we`=1 or `i_flush`=1 → `hold_valid`<=0.
- Decode: opcode[6:0], rd[11:7], funct3[14:12], rs1[19:15], rs2[24:20], funct7[31:25].
- Immediates: I, S, B, U and J formats, each sign-extended to 32 bits. B/J have bit 0 forced to 0. U is `{insn[31:12],12'b0}`. Format is selected by opcode into `imm`.
- Control: `alu_op`, `alu_src1_sel` (rs1/pc/zero), `alu_src2_sel` (rs2/imm), `branch`, `jump`, `mem_read`, `mem_write`, `mem_funct3`, `wb_sel` (alu/mem/pc+4/imm), `regf_we`.
- `regf_we` is forced to 0 when rd=0 or the opcode has no destination (branch/store).
- `illegal`=1 for opcodes outside RV32I base; illegal slots latch as a bubble with `illegal` flag set.
- Latch when `id_reg_we`=1:
  - If `i_flush`=1 or `insn_avail`=0: latch a bubble. Bubble = NOP fields, all write/mem enables 0, `rvfi.valid`=0.
  - Otherwise latch decoded fields, pc/pc_next from `i_if_stage_reg`, and rvfi. rvfi = IF rvfi plus insn, rs1/rs2 addr and rdata, rd_addr (0 if !regf_we).
- `id_reg_we`=0: `id_stage_reg` holds its value, except `i_flush`=1 forces a bubble. Flush wins over stall.

## Timing
- Reset: `id_stage_reg` = all zero (`rvfi.valid`=0, all enables 0); `hold_valid`=0, `hold_insn`=0.
- Latency: instruction returned in cycle N with `id_reg_we`=1 appears in `id_stage_reg` at N+1.
- Stall: response at cycle N, stall through N+k → latched at the first cycle with `id_reg_we`=1, from the hold register, with no second memory request.
- `rs1_addr`/`rs2_addr` are zero-latency combinational; their `rdata` is sampled the same cycle as the latch.
- Simultaneous `imem_resp` and `i_flush`: the response is discarded and is not captured into hold.
- Reset mid-stall: the held instruction is discarded; the next output is a bubble.

## Structure
- `rv32i_types` gets:
  - `id_stage_t` and its rvfi sub-struct.
  - Enums `alu_op_t`, `alu_src1_t`, `alu_src2_t`, `wb_sel_t`, `imm_fmt_t`.
  - Opcode constants (`op_lui`, `op_auipc`, `op_jal`, `op_jalr`, `op_br`, `op_load`, `op_store`, `op_imm`, `op_reg`) and `NOP_INSN`.
- One combinational sub-module `rv32i_decoder`: insn → fields, imm, control, illegal. `id_stage` owns the hold register, bubble muxing and pipeline register.

## Test plan
- Reset then idle with `imem_resp`=0 and `id_reg_we`=1 → `id_stage_reg.rvfi.valid`=0, `regf_we`=0 every cycle.
- `addi x1,x0,5` (0x00500093) with resp and we at pc 0x60000000 → next cycle: rd=1, imm=5, `regf_we`=1, `rvfi.pc_rdata`=0x60000000.
- `lui x5,0x12345` (0x123452B7) arrives with `id_reg_we`=0 for 3 cycles, then 1 → imm=0x12345000, rd=5, latched exactly once; output unchanged during the stall.
- `beq x1,x2,-8` (0xFE208CE3) → imm=0xFFFFFFF8, `branch`=1, `regf_we`=0, `rs1_addr`=1, `rs2_addr`=2 combinationally.
- Response in the same cycle as `i_flush`=1 → bubble latched; a following stall cycle still shows the bubble, and the hold register stays empty.
- `addi x0,x0,1` → `regf_we`=0, `rvfi.rd_addr`=0; opcode 0x7F → bubble with `illegal`=1.

Source files
------------

// File: rtl/id_stage_pkg.sv
// Shared RV32I types for the decode stage: opcodes, control enums,
// pipeline-register structs and the bubble constant.
package rv32i_types;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    localparam logic [6:0] op_lui   = 7'b0110111;
    localparam logic [6:0] op_auipc = 7'b0010111;
    localparam logic [6:0] op_jal   = 7'b1101111;
    localparam logic [6:0] op_jalr  = 7'b1100111;
    localparam logic [6:0] op_br    = 7'b1100011;
    localparam logic [6:0] op_load  = 7'b0000011;
    localparam logic [6:0] op_store = 7'b0100011;
    localparam logic [6:0] op_imm   = 7'b0010011;
    localparam logic [6:0] op_reg   = 7'b0110011;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_t;

    typedef enum logic [1:0] {SRC1_RS1, SRC1_PC, SRC1_ZERO} alu_src1_t;
    typedef enum logic {SRC2_RS2, SRC2_IMM} alu_src2_t;
    typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4, WB_IMM} wb_sel_t;
    typedef enum logic [2:0] {
        IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
    } imm_fmt_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] order;
        logic [31:0] insn;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [31:0] rs1_rdata;
        logic [31:0] rs2_rdata;
        logic [4:0]  rd_addr;
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
    } rvfi_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_next;
        rvfi_t       rvfi;
    } if_stage_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_next;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  funct7;
        logic [31:0] imm;
        alu_op_t     alu_op;
        alu_src1_t   alu_src1_sel;
        alu_src2_t   alu_src2_sel;
        logic        branch;
        logic        jump;
        logic        mem_read;
        logic        mem_write;
        logic [2:0]  mem_funct3;
        wb_sel_t     wb_sel;
        logic        regf_we;
        logic        illegal;
        rvfi_t       rvfi;
    } id_stage_t;

    // A bubble decodes like addi x0,x0,0 but never writes anything.
    function automatic id_stage_t bubble(input logic ill);
        id_stage_t b;
        b              = '0;
        b.opcode       = op_imm;
        b.alu_src2_sel = SRC2_IMM;
        b.illegal      = ill;
        return b;
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// Instruction-memory response and register-file read port seen by decode.
interface id_stage_if;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_rdata;
    logic [31:0] rs2_rdata;

    modport master (
        output imem_rdata, imem_resp, rs1_rdata, rs2_rdata,
        input  rs1_addr, rs2_addr
    );

    modport slave (
        input  imem_rdata, imem_resp, rs1_rdata, rs2_rdata,
        output rs1_addr, rs2_addr
    );
endinterface

// File: rtl/id_stage_decoder.sv
// Pure combinational RV32I decoder: fields, immediate, control, illegal.
module rv32i_decoder
    import rv32i_types::*;
(
    input  logic [31:0] insn_i,
    output id_stage_t   dec_o
);

    logic [6:0] opc;
    alu_op_t    arith;
    imm_fmt_t   fmt;
    logic       wr;

    assign opc = insn_i[6:0];

    always_comb begin
        arith = ALU_ADD;
        unique case (insn_i[14:12])
            3'b000: arith = (opc == op_reg && insn_i[30]) ? ALU_SUB : ALU_ADD;
            3'b001: arith = ALU_SLL;
            3'b010: arith = ALU_SLT;
            3'b011: arith = ALU_SLTU;
            3'b100: arith = ALU_XOR;
            3'b101: arith = insn_i[30] ? ALU_SRA : ALU_SRL;
            3'b110: arith = ALU_OR;
            3'b111: arith = ALU_AND;
        endcase
    end

    always_comb begin
        dec_o        = '0;
        fmt          = IMM_NONE;
        wr           = 1'b0;
        dec_o.opcode = opc;
        dec_o.rd     = insn_i[11:7];
        dec_o.funct3 = insn_i[14:12];
        dec_o.rs1    = insn_i[19:15];
        dec_o.rs2    = insn_i[24:20];
        dec_o.funct7 = insn_i[31:25];
        dec_o.alu_op = ALU_ADD;

        unique case (1'b1)
            opc == op_lui: begin
                fmt                = IMM_U;
                wr                 = 1'b1;
                dec_o.alu_src1_sel = SRC1_ZERO;
                dec_o.alu_src2_sel = SRC2_IMM;
                dec_o.wb_sel       = WB_IMM;
            end
            opc == op_auipc: begin
                fmt                = IMM_U;
                wr                 = 1'b1;
                dec_o.alu_src1_sel = SRC1_PC;
                dec_o.alu_src2_sel = SRC2_IMM;
            end
            opc == op_jal: begin
                fmt                = IMM_J;
                wr                 = 1'b1;
                dec_o.jump         = 1'b1;
                dec_o.alu_src1_sel = SRC1_PC;
                dec_o.alu_src2_sel = SRC2_IMM;
                dec_o.wb_sel       = WB_PC4;
            end
            opc == op_jalr: begin
                fmt                = IMM_I;
                wr                 = 1'b1;
                dec_o.jump         = 1'b1;
                dec_o.alu_src2_sel = SRC2_IMM;
                dec_o.wb_sel       = WB_PC4;
            end
            // ALU forms the target; the compare uses funct3 downstream.
            opc == op_br: begin
                fmt                = IMM_B;
                dec_o.branch       = 1'b1;
                dec_o.alu_src1_sel = SRC1_PC;
                dec_o.alu_src2_sel = SRC2_IMM;
            end
            opc == op_load: begin
                fmt                = IMM_I;
                wr                 = 1'b1;
                dec_o.mem_read     = 1'b1;
                dec_o.mem_funct3   = insn_i[14:12];
                dec_o.alu_src2_sel = SRC2_IMM;
                dec_o.wb_sel       = WB_MEM;
            end
            opc == op_store: begin
                fmt                = IMM_S;
                dec_o.mem_write    = 1'b1;
                dec_o.mem_funct3   = insn_i[14:12];
                dec_o.alu_src2_sel = SRC2_IMM;
            end
            opc == op_imm: begin
                fmt                = IMM_I;
                wr                 = 1'b1;
                dec_o.alu_op       = arith;
                dec_o.alu_src2_sel = SRC2_IMM;
            end
            opc == op_reg: begin
                wr           = 1'b1;
                dec_o.alu_op = arith;
            end
            default: dec_o.illegal = 1'b1;
        endcase

        unique case (fmt)
            IMM_I: dec_o.imm = {{20{insn_i[31]}}, insn_i[31:20]};
            IMM_S: dec_o.imm = {{20{insn_i[31]}}, insn_i[31:25], insn_i[11:7]};
            IMM_B: dec_o.imm = {{19{insn_i[31]}}, insn_i[31], insn_i[7],
                                insn_i[30:25], insn_i[11:8], 1'b0};
            IMM_U: dec_o.imm = {insn_i[31:12], 12'b0};
            IMM_J: dec_o.imm = {{11{insn_i[31]}}, insn_i[31], insn_i[19:12],
                                insn_i[20], insn_i[30:21], 1'b0};
            default: dec_o.imm = '0;
        endcase

        dec_o.regf_we = wr && (insn_i[11:7] != 5'd0);
    end

endmodule

// File: rtl/id_stage.sv
// Decode stage: instruction hold across stalls, bubble insertion and the
// id_stage_reg pipeline register with RVFI tracking.
module id_stage
    import rv32i_types::*;
(
    input  logic          clk,
    input  logic          rst,
    input  if_stage_t     i_if_stage_reg,
    id_stage_if.slave     bus,
    input  logic          id_reg_we,
    input  logic          i_flush,
    output id_stage_t     id_stage_reg
);

    logic        hold_valid_q, hold_valid_d;
    logic [31:0] hold_insn_q, hold_insn_d;
    logic [31:0] insn;
    logic        insn_avail;
    id_stage_t   dec;
    id_stage_t   id_d, id_q;

    assign insn_avail   = bus.imem_resp | hold_valid_q;
    assign insn         = bus.imem_resp ? bus.imem_rdata :
                          hold_valid_q  ? hold_insn_q    : NOP_INSN;
    assign bus.rs1_addr = insn[19:15];
    assign bus.rs2_addr = insn[24:20];
    assign id_stage_reg = id_q;

    rv32i_decoder u_dec (
        .insn_i (insn),
        .dec_o  (dec)
    );

    // A flushed response is dropped rather than parked in the hold register.
    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_insn_d  = hold_insn_q;
        if (i_flush || id_reg_we) begin
            hold_valid_d = 1'b0;
        end else if (bus.imem_resp) begin
            hold_valid_d = 1'b1;
            hold_insn_d  = bus.imem_rdata;
        end
    end

    always_comb begin
        id_d = id_q;
        if (i_flush) begin
            id_d = bubble(1'b0);
        end else if (id_reg_we) begin
            if (!insn_avail) begin
                id_d = bubble(1'b0);
            end else if (dec.illegal) begin
                id_d = bubble(1'b1);
            end else begin
                id_d                = dec;
                id_d.pc             = i_if_stage_reg.pc;
                id_d.pc_next        = i_if_stage_reg.pc_next;
                id_d.rvfi           = i_if_stage_reg.rvfi;
                id_d.rvfi.insn      = insn;
                id_d.rvfi.rs1_addr  = dec.rs1;
                id_d.rvfi.rs2_addr  = dec.rs2;
                id_d.rvfi.rs1_rdata = bus.rs1_rdata;
                id_d.rvfi.rs2_rdata = bus.rs2_rdata;
                id_d.rvfi.rd_addr   = dec.regf_we ? dec.rd : 5'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid_q <= 1'b0;
            hold_insn_q  <= '0;
            id_q         <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_insn_q  <= hold_insn_d;
            id_q         <= id_d;
        end
    end

endmodule
